// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and byte/column transforms for the iterative engine.
// Optional build macro AES_BCD_DISPLAY_EN uses seg7() for the decimal display outputs.
package aes_pkg;
  localparam int   AES_BLK_W = 128;
  localparam int   AES_NB    = 4;
  localparam logic AES_ENC   = 1'b0;
  localparam logic AES_DEC   = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} aes_fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // 9/11/13/14 multiples built from the x2/x4/x8 doubling chain
  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [3:0][7:0] m9, m11, m13, m14;
    logic [7:0] x, x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      x  = a[31-8*i -: 8];
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i]  = x8 ^ x;
      m11[i] = x8 ^ x2 ^ x;
      m13[i] = x8 ^ x4 ^ x;
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [AES_BLK_W-1:0] mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] r;
    for (int c = 0; c < AES_NB; c++) r[AES_BLK_W-1-32*c -: 32] = mix_col(s[AES_BLK_W-1-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [AES_BLK_W-1:0] inv_mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] r;
    for (int c = 0; c < AES_NB; c++) r[AES_BLK_W-1-32*c -: 32] = inv_mix_col(s[AES_BLK_W-1-32*c -: 32]);
    return r;
  endfunction

  // Active-low segments, bit order gfedcba
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction
endpackage

// File: rtl/aes_iter_engine_round.sv
// One combinational AES round, forward or inverse, with the final round skipping (Inv)MixColumns.
module aes_round_step
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] st_i,
  input  logic [AES_BLK_W-1:0] rkey_i,
  input  logic                 mode_i,
  input  logic                 last_i,
  output logic [AES_BLK_W-1:0] st_o
);
  logic [AES_BLK_W-1:0] enc_sr, dec_sb, enc_nxt, dec_ark, dec_nxt;

  // Byte i = 4*col + row sits at the MSB end; shift rows is folded into the S-box lookup index
  for (genvar c = 0; c < AES_NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int D  = AES_NB*c + r;
      localparam int SE = AES_NB*((c + r) % AES_NB) + r;
      localparam int SD = AES_NB*((c + AES_NB - r) % AES_NB) + r;
      assign enc_sr[AES_BLK_W-1-8*D -: 8] = sbox(st_i[AES_BLK_W-1-8*SE -: 8]);
      assign dec_sb[AES_BLK_W-1-8*D -: 8] = inv_sbox(st_i[AES_BLK_W-1-8*SD -: 8]);
    end
  end

  assign enc_nxt = (last_i ? enc_sr : mix_columns(enc_sr)) ^ rkey_i;
  assign dec_ark = dec_sb ^ rkey_i;
  assign dec_nxt = last_i ? dec_ark : inv_mix_columns(dec_ark);
  assign st_o    = (mode_i == AES_DEC) ? dec_nxt : enc_nxt;
endmodule

// File: rtl/aes_iter_engine.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one round per clock, valid/ready on both sides.
// Define AES_BCD_DISPLAY_EN to add hex0..hex2 showing the last delivered out_data[7:0] in decimal.
module aes_iter_engine
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [AES_BLK_W-1:0]         in_data,
  input  logic [(NR+1)*AES_BLK_W-1:0]  round_keys,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AES_BLK_W-1:0]         out_data,
  output logic                         out_mode,
  output logic                         busy,
  output logic [3:0]                   round_cnt
`ifdef AES_BCD_DISPLAY_EN
  ,
  output logic [6:0]                   hex0,
  output logic [6:0]                   hex1,
  output logic [6:0]                   hex2
`endif
);
  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("aes_iter_engine: NK must be 4, 6 or 8");
  end

  aes_fsm_e             fsm_q, fsm_d;
  logic [AES_BLK_W-1:0] st_q, od_q, step, rkey;
  logic [AES_BLK_W-1:0] keys [NR+1];
  logic [3:0]           rcnt_q, kidx;
  logic                 mode_q, ov_q, om_q, accept, last;

  for (genvar k = 0; k <= NR; k++) begin : g_key
    assign keys[k] = round_keys[(NR+1-k)*AES_BLK_W-1 -: AES_BLK_W];
  end

  // Decrypt walks the schedule backwards from key[NR]
  assign kidx = (mode_q == AES_DEC) ? 4'(NR) - rcnt_q : rcnt_q;
  assign rkey = keys[kidx];
  assign last = (rcnt_q == 4'(NR));

  aes_round_step u_step (
    .st_i   (st_q),
    .rkey_i (rkey),
    .mode_i (mode_q),
    .last_i (last),
    .st_o   (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = RUN;
      RUN:     if (last) fsm_d = DONE;
      DONE:    if (accept) fsm_d = RUN;
               else if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // rst_n gating keeps in_ready low for the whole reset window, not just after the first edge
  always_comb begin
    in_ready = rst_n && (fsm_q == IDLE || (fsm_q == DONE && out_ready));
    busy     = (fsm_q == RUN);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      mode_q <= AES_ENC;
      rcnt_q <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      om_q   <= AES_ENC;
    end else begin
      if (accept) begin
        st_q   <= in_data ^ ((in_mode == AES_DEC) ? keys[NR] : keys[0]);
        mode_q <= in_mode;
        rcnt_q <= 4'd1;
      end else if (busy) begin
        st_q   <= step;
        rcnt_q <= last ? 4'd0 : rcnt_q + 4'd1;
      end
      if (busy && last) begin
        ov_q <= 1'b1;
        od_q <= step;
        om_q <= mode_q;
      end else if (ov_q && out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_mode  = om_q;
  assign round_cnt = rcnt_q;

`ifdef AES_BCD_DISPLAY_EN
  logic [7:0] disp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  disp_q <= '0;
    else if (ov_q && out_ready)  disp_q <= od_q[7:0];
  end

  assign hex2 = seg7(4'(disp_q / 8'd100));
  assign hex1 = seg7(4'((disp_q / 8'd10) % 8'd10));
  assign hex0 = seg7(4'(disp_q % 8'd10));
`endif
endmodule

// File: tb/tb_aes_iter_engine.sv
// Bench for aes_iter_engine: NK=4/6/8 instances share one input stream and are checked against
// FIPS-197 vectors and a byte-level AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_iter_engine;
  localparam int KW = 15*128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_mode, out_ready;
  logic [127:0] in_data;
  logic [11*128-1:0] rk4;
  logic [13*128-1:0] rk6;
  logic [15*128-1:0] rk8;
  logic ir4, ir6, ir8, ov4, ov6, ov8, om4, om6, om8, bz4, bz6, bz8;
  logic [127:0] od4, od6, od8;
  logic [3:0] rc4, rc6, rc8;
`ifdef AES_BCD_DISPLAY_EN
  logic [6:0] h0_4, h1_4, h2_4, h0_6, h1_6, h2_6, h0_8, h1_8, h2_8;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [KW-1:0] ek4, ek6, ek8;

  aes_iter_engine #(.NK(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
    .in_mode(in_mode), .in_data(in_data), .round_keys(rk4), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_mode(om4), .busy(bz4), .round_cnt(rc4)
`ifdef AES_BCD_DISPLAY_EN
    , .hex0(h0_4), .hex1(h1_4), .hex2(h2_4)
`endif
  );
  aes_iter_engine #(.NK(6)) u6 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir6),
    .in_mode(in_mode), .in_data(in_data), .round_keys(rk6), .out_valid(ov6), .out_ready(out_ready),
    .out_data(od6), .out_mode(om6), .busy(bz6), .round_cnt(rc6)
`ifdef AES_BCD_DISPLAY_EN
    , .hex0(h0_6), .hex1(h1_6), .hex2(h2_6)
`endif
  );
  aes_iter_engine #(.NK(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .in_mode(in_mode), .in_data(in_data), .round_keys(rk8), .out_valid(ov8), .out_ready(out_ready),
    .out_data(od8), .out_mode(om8), .busy(bz8), .round_cnt(rc8)
`ifdef AES_BCD_DISPLAY_EN
    , .hex0(h0_8), .hex1(h1_8), .hex2(h2_8)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = sb[w[31-8*j -: 8]];
    return r;
  endfunction

  // key bytes are MSB-aligned in a 256-bit word; schedule returned with key 0 at the MSBs
  function automatic logic [KW-1:0] expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [KW-1:0] r;
    int nw;
    nw = 4*(nk + 7);
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) r[KW-1-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] ref_cipher(input logic [127:0] blk, input logic dec,
                                              input logic [KW-1:0] rk, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] r;
    int c, rw, k;
    k = dec ? nr : 0;
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ rk[KW-1-128*k-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      k = dec ? nr - rnd : rnd;
      for (int i = 0; i < 16; i++) begin
        c = i / 4; rw = i % 4;
        if (!dec) t[i] = sb[s[4*((c + rw) % 4) + rw]];
        else      t[i] = isb[s[4*((c + 4 - rw) % 4) + rw]] ^ rk[KW-1-128*k-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) begin
        c = 4*(i / 4); rw = i % 4;
        if (rnd == nr) s[i] = t[i];
        else if (!dec) s[i] = gmul(8'h02, t[c+rw]) ^ gmul(8'h03, t[c+(rw+1)%4])
                            ^ t[c+(rw+2)%4] ^ t[c+(rw+3)%4];
        else s[i] = gmul(8'h0e, t[c+rw]) ^ gmul(8'h0b, t[c+(rw+1)%4])
                  ^ gmul(8'h0d, t[c+(rw+2)%4]) ^ gmul(8'h09, t[c+(rw+3)%4]);
        if (!dec) s[i] = s[i] ^ rk[KW-1-128*k-8*i -: 8];
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_keys(input logic [255:0] k4, input logic [255:0] k6, input logic [255:0] k8);
    ek4 = expand(k4, 4);
    ek6 = expand(k6, 6);
    ek8 = expand(k8, 8);
    rk4 = ek4[KW-1 -: 11*128];
    rk6 = ek6[KW-1 -: 13*128];
    rk8 = ek8[KW-1 -: 15*128];
  endtask

  // Call at a negedge with in_valid/in_data/in_mode already driven; the next edge is the accept
  // edge, counted as edge 1. Expected latency is NR+1 edges inclusive.
  task automatic collect(input string tag, input logic [127:0] e4, input logic [127:0] e6,
                         input logic [127:0] e8, input logic m);
    int lat [3];
    logic [127:0] d [3];
    logic md [3];
    bit seen [3];
    int e;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; d[i] = '0; md[i] = 1'b0; seen[i] = 1'b0; end
    out_ready = 1'b1;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy"}, 128'({bz4, bz6, bz8, rc4}), 128'({3'b111, 4'd1}));
    while (e < 24) begin
      if (!seen[0] && ov4) begin seen[0] = 1'b1; lat[0] = e; d[0] = od4; md[0] = om4; end
      if (!seen[1] && ov6) begin seen[1] = 1'b1; lat[1] = e; d[1] = od6; md[1] = om6; end
      if (!seen[2] && ov8) begin seen[2] = 1'b1; lat[2] = e; d[2] = od8; md[2] = om8; end
      if (seen[0] && seen[1] && seen[2]) break;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    chk({tag, "_lat4"}, 128'(lat[0]), 128'(11));
    chk({tag, "_lat6"}, 128'(lat[1]), 128'(13));
    chk({tag, "_lat8"}, 128'(lat[2]), 128'(15));
    chk({tag, "_data4"}, d[0], e4);
    chk({tag, "_data6"}, d[1], e6);
    chk({tag, "_data8"}, d[2], e8);
    chk({tag, "_mode"}, 128'({md[0], md[1], md[2]}), 128'({m, m, m}));
  endtask

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] FK4  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] FK6  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] FK8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [255:0] rkey4, rkey6, rkey8;
    logic [127:0] rdata;
    logic rmode;
    int e;
    bit bad;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
    build_sbox();
    set_keys(FK4, FK6, FK8);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 128'({ir4, ov4, om4, bz4, rc4}), 128'(0));
    chk("rst_data", od4, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 128'({ir4, ir6, ir8, bz4}), 128'(4'b1110));

    // FIPS-197 encrypt vectors on all three key lengths
    in_valid = 1'b1; in_data = PT; in_mode = 1'b0;
    collect("fips_enc", CT4, CT6, CT8, 1'b0);
`ifdef AES_BCD_DISPLAY_EN
    chk("bcd_digits", 128'({h2_4, h1_4, h0_4}), 128'({7'h40, 7'h10, 7'h40}));
`endif

    // decrypt of the AES-128 ciphertext
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_data = CT4; in_mode = 1'b1;
    collect("fips_dec", PT, ref_cipher(CT4, 1'b1, ek6, 12), ref_cipher(CT4, 1'b1, ek8, 14), 1'b1);

    // backpressure: result must hold, no new accept while it is unconsumed
    repeat (2) @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = PT; in_mode = 1'b0;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!ov4 && e < 24) begin
      @(posedge clk); e++; @(negedge clk);
    end
    chk("bp_lat4", 128'(e), 128'(11));
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (od4 !== CT4 || ir4 !== 1'b0 || ov4 !== 1'b1 || om4 !== 1'b0) bad = 1'b1;
    end
    chk("bp_hold", 128'(bad), 128'(0));
    chk("bp_data", od4, CT4);
    // drain and accept on the same edge
    out_ready = 1'b1; in_valid = 1'b1; in_data = CT4; in_mode = 1'b1;
    #1;
    chk("b2b_ready", 128'({ir4, ir6, ir8}), 128'(3'b111));
    collect("b2b", PT, ref_cipher(CT4, 1'b1, ek6, 12), ref_cipher(CT4, 1'b1, ek8, 14), 1'b1);

    // reset in the middle of a block
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_data = PT; in_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    e = 0;
    while (rc4 !== 4'd5 && e < 12) begin
      @(posedge clk); e++; @(negedge clk);
    end
    chk("mid_round5", 128'(rc4), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 128'({ir4, ov4, om4, bz4, rc4, ov6, ov8}), 128'(0));
    chk("mid_rst_data", od4, 128'h0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ov4 !== 1'b0 || od4 !== 128'h0) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (ov4 !== 1'b0 || ov6 !== 1'b0 || ov8 !== 1'b0) bad = 1'b1;
    end
    chk("mid_no_valid", 128'(bad), 128'(0));
    chk("mid_recover", 128'({ir4, bz4, rc4}), 128'({1'b1, 1'b0, 4'd0}));
    in_valid = 1'b1; in_data = PT; in_mode = 1'b0;
    collect("post_rst", CT4, CT6, CT8, 1'b0);

    // randomized keys, blocks and modes against the model
    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < 8; j++) begin
        rkey4[255-32*j -: 32] = $urandom;
        rkey6[255-32*j -: 32] = $urandom;
        rkey8[255-32*j -: 32] = $urandom;
      end
      for (int j = 0; j < 4; j++) rdata[127-32*j -: 32] = $urandom;
      rmode = 1'($urandom_range(0, 1));
      @(negedge clk);
      set_keys(rkey4, rkey6, rkey8);
      in_valid = 1'b1; in_data = rdata; in_mode = rmode;
      collect($sformatf("rand%0d", n), ref_cipher(rdata, rmode, ek4, 10),
              ref_cipher(rdata, rmode, ek6, 12), ref_cipher(rdata, rmode, ek8, 14), rmode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
